pwm_capture: RTL
================

# pwm_capture

Measures a PWM waveform, such as the duty-stepped output of the PWM generator, by counting clock cycles. For each full period it reports the period length and the high time, and it flags lines that are stuck high or stuck low. It sits directly downstream of the PWM generator. It is used for self-check and loop-back on the same die, and for capturing an external PWM on a dedicated input pin.

## Interface
- `CNT_W`, default 16: width of the measurement counters and outputs.
- `TIMEOUT`, default 1023: number of cycles with no edge before a stuck condition is declared. Must be ≥ 2 and ≤ 2^CNT_W−1.

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `ena`, in, 1: measurement enable; when low the block is held idle.
- `pwm_in`, in, 1: PWM input; may be asynchronous to `clk`.
- `period_cnt`, out, CNT_W: last measured period in clk cycles.
- `high_cnt`, out, CNT_W: last measured high time in clk cycles.
- `meas_valid`, out, 1: one-cycle pulse when `period_cnt` and `high_cnt` update.
- `ovf`, out, 1: set with `meas_valid` if either reported value saturated; holds until the next `meas_valid`.
- `stuck_high`, out, 1: level; no edge for TIMEOUT cycles while the input is high.
- `stuck_low`, out, 1: level; no edge for TIMEOUT cycles while the input is low.

## Operation
- **Synchroniser and edge detection.** `pwm_in` passes through two flops, s1 and s2. A third flop, s3, holds the previous s2.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - edge = rise | fall
- **States.** There are three: IDLE, ARM and MEAS.
  - IDLE: entered on reset or whenever `ena` = 0. Accumulators and the idle counter are cleared. Stuck flags are cleared. Result outputs hold their values. Goes to ARM when `ena` = 1.
  - ARM: waits for the first rise. On rise → MEAS, with period_acc = 1, high_acc = 1 and no publish.
  - MEAS: each cycle without a rise:
    - period_acc += 1
    - high_acc += s2
    - both saturate at 2^CNT_W−1 and record a sticky saturation bit.
  - Rise in MEAS: publish, then restart the accumulators at 1/1 and clear the saturation bit.
- **Publish.** `period_cnt` ← period_acc, `high_cnt` ← high_acc, `ovf` ← saturation bit, and `meas_valid` = 1 for exactly one cycle.
- **Measurement window.** The reported period counts cycles from one detected rise up to the cycle before the next. The high time counts the cycles in that window where s2 = 1.
- **Idle counter.** Cleared on any edge and incremented otherwise, saturating at TIMEOUT. Counts in ARM and in MEAS.
- **Timeout.** When the idle counter reaches TIMEOUT (in ARM or MEAS):
  - go to ARM and discard the accumulators;
  - set `stuck_high` if s2 = 1, else set `stuck_low`.
- **Stuck flags.** Both clear on the next edge. The first rise after a timeout only arms; the first `meas_valid` follows the second rise.
- **Simultaneous timeout and edge.** The edge wins: the idle counter clears and no flag is set.
- **Duty extremes.** 0% duty yields `stuck_low`; 100% duty yields `stuck_high`. Neither produces `meas_valid`.
- **Disable.** `ena` falling in the middle of a measurement abandons the partial period; no publish occurs.

## Timing
- **Reset values.** All outputs are 0, state is IDLE, and s1/s2/s3 and all counters are 0.
- **Input latency.** An edge on `pwm_in` (stable across `clk`) is detected as rise/fall 2 cycles after it is sampled into s1.
- **Publish timing.** `meas_valid`, `period_cnt`, `high_cnt` and `ovf` are registered. They update on the clock edge at which rise is sampled, so they are visible in the following cycle.
- **Reset mid-operation.** `rst_n` low on any edge returns every register to its reset value on that edge. After release, the first `meas_valid` requires two detected rises.
- **No throughput limit.** A rise every 2 cycles (period 2) is measured correctly.

## Test plan
- **Steady PWM.** Generator output with period 10 and duty 5, `ena` = 1 → first `meas_valid` after the second rise, reporting `period_cnt` = 10 and `high_cnt` = 5, then a pulse every 10 cycles; `ovf` = 0.
- **Duty step.** Step duty 5→6 at a period boundary → the next full period reports 6/10. Step duty to 9 → reports 9/10.
- **Stuck low.** `TIMEOUT` = 64, input held low after a falling edge → `stuck_low` = 1 exactly 64 cycles after the fall is detected; no `meas_valid`. Restart the PWM → the flag clears on the first rise, and `meas_valid` follows the second rise.
- **Stuck high.** Duty 10/10 (input held high) → `stuck_high` after TIMEOUT cycles; `stuck_low` stays 0.
- **Saturation.** `CNT_W` = 4, `TIMEOUT` = 15, period 20 with 10 high → `period_cnt` = 15, `high_cnt` = 10, `ovf` = 1. A later 10/5 input → reports 10/5 with `ovf` = 0.
- **Reset and disable mid-period.** `rst_n` low for 1 cycle mid-period → all outputs 0 on the next cycle, and measurement resumes only after two rises. Same stimulus with `ena` dropped instead → no publish, and the results hold their previous values.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture with stuck-line detection
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             ovf,
    output logic             stuck_high,
    output logic             stuck_low
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            state;
    logic              s1, s2, s3;
    logic [CNT_W-1:0]  period_acc;
    logic [CNT_W-1:0]  high_acc;
    logic [CNT_W-1:0]  idle_cnt;
    logic              sat;

    logic rise, fall, edge_det, timeout_hit;

    assign rise        = s2 & ~s3;
    assign fall        = ~s2 & s3;
    assign edge_det    = rise | fall;
    // An edge in the same cycle always wins over the timeout.
    assign timeout_hit = (idle_cnt == TO_LAST) && !edge_det;

    // Two-flop synchroniser plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measurement FSM: accumulate between rises, publish on rise, timeout to ARM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_acc <= '0;
            high_acc   <= '0;
            idle_cnt   <= '0;
            sat        <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            ovf        <= 1'b0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!ena) begin
                state      <= IDLE;
                period_acc <= '0;
                high_acc   <= '0;
                idle_cnt   <= '0;
                sat        <= 1'b0;
                stuck_high <= 1'b0;
                stuck_low  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM, MEAS: begin
                        if (edge_det) begin
                            idle_cnt   <= '0;
                            stuck_high <= 1'b0;
                            stuck_low  <= 1'b0;
                        end else if (idle_cnt != TO_VAL) begin
                            idle_cnt <= idle_cnt + ONE;
                        end

                        if (rise) begin
                            if (state == MEAS) begin
                                period_cnt <= period_acc;
                                high_cnt   <= high_acc;
                                ovf        <= sat;
                                meas_valid <= 1'b1;
                            end
                            state      <= MEAS;
                            period_acc <= ONE;
                            high_acc   <= ONE;
                            sat        <= 1'b0;
                        end else if (timeout_hit) begin
                            state      <= ARM;
                            period_acc <= '0;
                            high_acc   <= '0;
                            sat        <= 1'b0;
                            stuck_high <= s2;
                            stuck_low  <= ~s2;
                        end else if (state == MEAS) begin
                            if (period_acc != CNT_MAX) begin
                                period_acc <= period_acc + ONE;
                            end
                            if (s2 && (high_acc != CNT_MAX)) begin
                                high_acc <= high_acc + ONE;
                            end
                            sat <= sat | (period_acc == CNT_MAX) | (s2 & (high_acc == CNT_MAX));
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
